// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared CPU types used by the instruction cache: the 32-bit word type, the
// cache FSM state encoding, and the frame/address structs for the default
// 16-frame geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef logic [31:0] word_t;

  // Default cache geometry.
  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDX   = $clog2(ICACHE_NSETS);
  localparam int ICACHE_TAGW  = 30 - ICACHE_IDX;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // One cache frame: a single instruction word plus its tag and valid bit.
  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  // Fetch address viewed as {tag, index, byte offset}.
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDX-1:0]  idx;
    logic [1:0]             bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Instruction half of the datapath/cache and cache/memory-controller buses.
//   imemREN  : datapath fetch request
//   imemaddr : fetch byte address
//   imemload : instruction word returned on a hit (0 otherwise)
//   ihit     : fetch hit this cycle
//   iREN     : read request to the memory controller
//   iaddr    : word-aligned fill address
//   iload    : fill data from the memory controller
//   iwait    : memory controller busy
// Modports:
//   slave  - the cache itself
//   master - the surrounding environment (datapath fetch + memory controller)
// -----------------------------------------------------------------------------
interface icache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  word_t imemload;
  logic  ihit;
  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  iwait;

  modport slave (
    input  imemREN, imemaddr, iload, iwait,
    output imemload, ihit, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iload, iwait,
    input  imemload, ihit, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache with one-word frames. Hits return
// the instruction combinationally in the same cycle; a miss drops ihit and runs
// a single-word fill from the memory controller, after which the fetch is
// looked up again and hits.
// Parameters:
//   NSETS : number of frames (power of two, >= 2)
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   bus   : icache_if.slave (fetch port + memory-controller instruction port)
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS
) (
  input  logic     CLK,
  input  logic     RST,
  icache_if.slave  bus
);

  localparam int IDX  = $clog2(NSETS);
  localparam int TAGW = 30 - IDX;

  // Same layout as icache_frame_t / icachef_t, sized for this instance's NSETS.
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    word_t           data;
  } frame_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [IDX-1:0]  idx;
    logic [1:0]      bytoff;
  } addr_t;

  frame_t          r_frames [NSETS];
  icache_state_t   r_state;
  icache_state_t   w_next_state;
  logic [TAGW-1:0] r_miss_tag;
  logic [IDX-1:0]  r_miss_idx;

  addr_t  w_addr;
  frame_t w_frame;
  logic   w_lookup_hit;
  logic   w_miss_start;
  logic   w_fill_done;
  logic   w_unused_bytoff;

  assign w_addr          = addr_t'(bus.imemaddr);
  assign w_frame         = r_frames[w_addr.idx];
  assign w_lookup_hit    = w_frame.valid && (w_frame.tag == w_addr.tag);
  // Instruction fetches are word-granular; the byte offset carries no information.
  assign w_unused_bytoff = ^w_addr.bytoff;

  // Next-state logic and all bus outputs.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_miss_start = 1'b0;
    w_fill_done  = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;

    unique case (r_state)
      IDLE: begin
        if (bus.imemREN) begin
          if (w_lookup_hit) begin
            bus.ihit     = 1'b1;
            bus.imemload = w_frame.data;
          end else begin
            w_miss_start = 1'b1;
            w_next_state = FILL;
          end
        end
      end

      FILL: begin
        // The fill targets the latched miss address, so a branch redirect on
        // imemaddr during FILL does not disturb iaddr or the frame written.
        bus.iREN  = 1'b1;
        bus.iaddr = {r_miss_tag, r_miss_idx, 2'b00};
        if (!bus.iwait) begin
          w_fill_done  = 1'b1;
          w_next_state = IDLE;
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  // Frame array, FSM state and miss register.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
      // NOTE: only the valid bits are cleared; tag and data are don't-care
      // while invalid, so the storage arrays carry no reset.
      for (int i = 0; i < NSETS; i++) begin
        r_frames[i].valid <= 1'b0;
      end
    end else begin
      r_state <= w_next_state;
      if (w_miss_start) begin
        r_miss_tag <= w_addr.tag;
        r_miss_idx <= w_addr.idx;
      end
      // A fill unconditionally overwrites its frame (silent eviction).
      if (w_fill_done) begin
        r_frames[r_miss_idx] <= '{valid: 1'b1, tag: r_miss_tag, data: bus.iload};
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Scoreboard bench for icache. Stimulus pushes the expected hit data and the
// expected fill addresses into queues; a monitor running on the falling edge
// pops and compares whenever the cache reports a hit or a fill completes. A
// small memory model answers fill requests with a programmable wait count.
// -----------------------------------------------------------------------------
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  icache_if bus();

  icache #(.NSETS(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t addr;
    word_t data;
  } hit_t;

  hit_t  hit_q  [$];
  word_t fill_q [$];
  word_t mem    [word_t];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  int mem_waits   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory controller model: holds iwait for mem_waits cycles of each fill,
  // then drops it for one cycle with the word on iload.
  initial begin
    int wcnt;
    wcnt      = 0;
    bus.iwait = 1'b0;
    bus.iload = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.iREN) begin
        if (wcnt < mem_waits) begin
          bus.iwait = 1'b1;
          wcnt++;
        end else begin
          bus.iwait = 1'b0;
          bus.iload = mem.exists(bus.iaddr) ? mem[bus.iaddr] : 32'hDEADBEEF;
          wcnt      = 0;
        end
      end else begin
        bus.iwait = 1'b0;
        bus.iload = '0;
        wcnt      = 0;
      end
    end
  end

  // Monitor: compares DUT responses against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.ihit) begin
          if (hit_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_hit: addr %h data %h (t=%0t)", bus.imemaddr, bus.imemload, $time);
          end else begin
            hit_t e;
            e = hit_q.pop_front();
            check("hit_data", bus.imemload, e.data);
          end
        end else begin
          check("imemload_zero_on_miss", bus.imemload, '0);
        end

        if (bus.iREN) begin
          check("no_hit_in_fill", word_t'(bus.ihit), '0);
          if (fill_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_fill: iaddr %h (t=%0t)", bus.iaddr, $time);
          end else begin
            check("fill_iaddr", bus.iaddr, fill_q[0]);
            if (!bus.iwait) void'(fill_q.pop_front());
          end
        end else begin
          check("iaddr_zero_idle", bus.iaddr, '0);
        end
      end
    end
  end

  // Counts falling edges until ihit (bounded), then releases the request.
  task automatic wait_hit(input int exp_cycles, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ihit && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, word_t'(n), word_t'(exp_cycles));
    @(posedge clk);
    #2;
    bus.imemREN = 1'b0;
  endtask

  // Waits (bounded) for the fill completion cycle; called from inside FILL.
  task automatic wait_fill_done(input int exp_cycles, input string name);
    int n;
    n = 0;
    while (!(bus.iREN && !bus.iwait) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, word_t'(n), word_t'(exp_cycles));
  endtask

  // One fetch: miss penalty is detect + waits + completion = waits+2 cycles.
  task automatic fetch(input word_t addr, input bit miss, input word_t data,
                       input int waits, input string name);
    mem_waits = waits;
    if (miss) fill_q.push_back({addr[31:2], 2'b00});
    hit_q.push_back('{addr: addr, data: data});
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    check({name, "_iren_at_lookup"}, word_t'(bus.iREN), '0);
    wait_hit(miss ? waits + 2 : 0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h0000_0040] = 32'h8C22_0004;
    mem[32'h0000_0440] = 32'h2001_0005;
    mem[32'h0000_0080] = 32'h3C01_1234;
    mem[32'h0000_0100] = 32'hAC22_0008;
    mem[32'h0000_0200] = 32'h0085_1020;

    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;

    // Reset for two cycles, then check reset outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ihit",     word_t'(bus.ihit), '0);
    check("rst_iren",     word_t'(bus.iREN), '0);
    check("rst_iaddr",    bus.iaddr, '0);
    check("rst_imemload", bus.imemload, '0);
    mon_en = 1'b1;
    @(posedge clk);
    #2;

    // Cold miss with 3 wait cycles: hit on the 6th cycle; then a same-cycle hit.
    fetch(32'h0000_0040, 1'b1, 32'h8C22_0004, 3, "cold_miss");
    fetch(32'h0000_0040, 1'b0, 32'h8C22_0004, 0, "hit_after_fill");

    // Conflict eviction at idx 0, including a zero-wait fill.
    fetch(32'h0000_0440, 1'b1, 32'h2001_0005, 2, "conflict_fill");
    fetch(32'h0000_0440, 1'b0, 32'h2001_0005, 0, "conflict_hit");
    fetch(32'h0000_0040, 1'b1, 32'h8C22_0004, 0, "evicted_refill");
    fetch(32'h0000_0043, 1'b0, 32'h8C22_0004, 0, "byte_offset_ignored");

    // Redirect mid-fill with imemREN held: the 0x80 fill completes, and the
    // redirected 0x100 misses in the very next IDLE cycle.
    mem_waits = 2;
    fill_q.push_back(32'h0000_0080);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0080;
    @(posedge clk);
    #2;
    bus.imemaddr = 32'h0000_0100;
    wait_fill_done(2, "redirect_fill_len");
    fill_q.push_back(32'h0000_0100);
    hit_q.push_back('{addr: 32'h0000_0100, data: 32'hAC22_0008});
    wait_hit(5, "redirect_next_miss");

    // Redirect with imemREN dropped: frame 0 must end up holding 0x80.
    mem_waits = 1;
    fill_q.push_back(32'h0000_0080);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0080;
    @(posedge clk);
    #2;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0100;
    wait_fill_done(1, "redirect2_fill_len");
    @(posedge clk);
    #2;
    fetch(32'h0000_0080, 1'b0, 32'h3C01_1234, 0, "redirect_tag_kept");
    fetch(32'h0000_0100, 1'b1, 32'hAC22_0008, 0, "redirect_other_miss");

    // Reset in the completion cycle aborts the fill.
    mem_waits = 2;
    fill_q.push_back(32'h0000_0200);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0200;
    @(posedge clk);
    #2;
    bus.imemREN = 1'b0;
    wait_fill_done(2, "abort_fill_len");
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_iren_dropped", word_t'(bus.iREN), '0);
    @(posedge clk);
    #2;
    fetch(32'h0000_0200, 1'b1, 32'h0085_1020, 1, "abort_refetch_miss");

    // imemREN low on an uncached address: nothing happens.
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ren_low_ihit",     word_t'(bus.ihit), '0);
      check("ren_low_iren",     word_t'(bus.iREN), '0);
      check("ren_low_imemload", bus.imemload, '0);
      @(posedge clk);
      #2;
    end

    repeat (2) @(posedge clk);
    check("hit_q_drained",  word_t'(hit_q.size()),  '0);
    check("fill_q_drained", word_t'(fill_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
